// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command sequencer driving an external 7-bit ALU from a 4-entry register file
//
// Optional feature macro: ALU_SEQ_REPEAT_EN (ALU ops run cmd_cnt+1 times).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_rd/ra/rb        opcode and register indices
//   cmd_imm_en, cmd_imm         immediate substitution for operand B
//   cmd_cnt                     repeat count (used only with ALU_SEQ_REPEAT_EN)
//   alu_a, alu_b, alu_opsel     registered operands/opcode to the external ALU
//   alu_result, alu_carry/ovf/zero/neg  ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_flags         final rd value and {carry, ovf, zero, neg}
//   busy                        sequencer is not idle
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic       cmd_imm_en,
    input  logic [6:0] cmd_imm,
    input  logic [2:0] cmd_cnt,
    output logic [6:0] alu_a,
    output logic [6:0] alu_b,
    output logic [2:0] alu_opsel,
    input  logic [6:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    input  logic       alu_zero,
    input  logic       alu_neg,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [6:0] rsp_data,
    output logic [3:0] rsp_flags,
    output logic       busy
);

    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_RESP
    } state_t;

    state_t     state, state_nx;

    logic [6:0] regs [4];
    logic [2:0] op_q;
    logic [1:0] rd_q, ra_q, rb_q;
    logic       imm_en_q;
    logic [6:0] imm_q;
    logic [6:0] res_q;
    logic [3:0] flg_q;
    logic [3:0] flag_reg;
    logic       more_iter;

`ifdef ALU_SEQ_REPEAT_EN
    logic [2:0] cnt_q;
    assign more_iter = (cnt_q != 3'd0);
`else
    logic unused_cnt;
    assign unused_cnt = ^cmd_cnt;
    assign more_iter  = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (cmd_valid) state_nx = S_READ;
            S_READ: begin
                if (op_q == OP_NOP)       state_nx = S_RESP;
                else if (op_q == OP_LOAD) state_nx = S_WB;
                else                      state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_WB;
            // LOAD never repeats, whatever the latched count says
            S_WB:   state_nx = (op_q != OP_LOAD && more_iter) ? S_READ : S_RESP;
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            imm_en_q  <= 1'b0;
            imm_q     <= '0;
            res_q     <= '0;
            flg_q     <= '0;
            flag_reg  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_opsel <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
`ifdef ALU_SEQ_REPEAT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q     <= cmd_op;
                    rd_q     <= cmd_rd;
                    ra_q     <= cmd_ra;
                    rb_q     <= cmd_rb;
                    imm_en_q <= cmd_imm_en;
                    imm_q    <= cmd_imm;
`ifdef ALU_SEQ_REPEAT_EN
                    cnt_q    <= cmd_cnt;
`endif
                end
                S_READ: begin
                    alu_a     <= regs[ra_q];
                    alu_b     <= imm_en_q ? imm_q : regs[rb_q];
                    alu_opsel <= op_q;
                    if (op_q == OP_NOP) begin
                        rsp_data  <= regs[rd_q];
                        rsp_flags <= flag_reg;
                    end
                end
                S_EXEC: begin
                    res_q <= alu_result;
                    flg_q <= {alu_carry, alu_ovf, alu_zero, alu_neg};
                end
                S_WB: begin
                    if (op_q == OP_LOAD) begin
                        regs[rd_q] <= imm_q;
                        rsp_data   <= imm_q;
                        rsp_flags  <= flag_reg;
                    end else begin
                        // Written here so a following READ with ra==rd sees it
                        regs[rd_q] <= res_q;
                        flag_reg   <= flg_q;
                        rsp_data   <= res_q;
                        rsp_flags  <= flg_q;
`ifdef ALU_SEQ_REPEAT_EN
                        if (more_iter) cnt_q <= cnt_q - 3'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
